// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for NTT datapath blocks.
//   state_t     : two-state stream controller encoding (IDLE / STREAM)
//   bit_reverse : reverses the low 'width' bits of an index; reused by the
//                 NTT address generators as well as the coefficient serializer.
package ntt_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam int unsigned IDX_MAX_W = 32;

   // Bits at or above 'width' come back as zero.
   function automatic logic [IDX_MAX_W-1:0] bit_reverse(
      input logic [IDX_MAX_W-1:0] idx,
      input int unsigned          width
   );
      logic [IDX_MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < IDX_MAX_W; i++) begin
         if (i < width) r[width-1-i] = idx[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/coeff_serializer_if.sv
// coeff_serializer_if: load/stream bus of the coefficient serializer.
//   load, bitrev, data_in : stream request, order mode, packed coefficient vector
//   out_word, out_valid   : current word and its valid flag
//   out_ready             : consumer accept
//   sel                   : index of the word on out_word
//   busy, done            : stream in progress / one-cycle end-of-stream pulse
// modport slave is the serializer's view, master the requester/consumer view.
interface coeff_serializer_if #(
   parameter int unsigned N = 4,
   parameter int unsigned S = 16
);
   logic                 load;
   logic                 bitrev;
   logic [S*N-1:0]       data_in;
   logic [N-1:0]         out_word;
   logic                 out_valid;
   logic                 out_ready;
   logic [$clog2(S)-1:0] sel;
   logic                 busy;
   logic                 done;

   modport slave (
      input  load, bitrev, data_in, out_ready,
      output out_word, out_valid, sel, busy, done
   );

   modport master (
      output load, bitrev, data_in, out_ready,
      input  out_word, out_valid, sel, busy, done
   );
endinterface

// File: rtl/coeff_serializer_mux.sv
// mux: selects word 'sel' of an S-word packed vector of N-bit words.
//   a   : packed vector, word i = a[i*N +: N]
//   sel : word index
//   s   : selected word
module mux #(
   parameter int unsigned N = 4,
   parameter int unsigned S = 16
) (
   input  logic [S*N-1:0]       a,
   input  logic [$clog2(S)-1:0] sel,
   output logic [N-1:0]         s
);
   assign s = a[sel*N +: N];
endmodule

// File: rtl/coeff_serializer.sv
// coeff_serializer: captures a packed vector of S coefficient words on load and
// streams them out one word per handshake, in natural or bit-reversed index order.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : coeff_serializer_if.slave (load/bitrev/data_in in, word stream out,
//         sel, busy, done)
module coeff_serializer
   import ntt_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned S = 16
) (
   input  logic                clk,
   input  logic                rst,
   coeff_serializer_if.slave   bus
);
   localparam int unsigned SW = $clog2(S);
   typedef logic [SW-1:0] idx_t;
   localparam idx_t LAST = idx_t'(S - 1);

   state_t         r_state;
   logic [S*N-1:0] r_vec;
   logic           r_mode;
   idx_t           r_count;
   logic           r_valid;
   logic           r_busy;
   logic           r_done;

   idx_t           w_sel;
   logic [N-1:0]   w_word;
   logic           w_hs;

   assign w_hs  = r_valid & bus.out_ready;
   assign w_sel = r_mode ? idx_t'(bit_reverse(IDX_MAX_W'(r_count), SW)) : r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_vec   <= '0;
         r_mode  <= 1'b0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // done may be high here; a load in that cycle is still taken
               if (bus.load) begin
                  r_vec   <= bus.data_in;
                  r_mode  <= bus.bitrev;
                  r_count <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= STREAM;
               end
            end
            STREAM: begin
               if (w_hs) begin
                  if (r_count == LAST) begin
                     r_count <= '0;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mux #(.N(N), .S(S)) u_mux (
      .a   (r_vec),
      .sel (w_sel),
      .s   (w_word)
   );

   assign bus.out_word  = w_word;
   assign bus.out_valid = r_valid;
   assign bus.sel       = w_sel;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_coeff_serializer.sv
// tb_coeff_serializer: directed + scoreboard bench for coeff_serializer (N=4, S=16).
module tb_coeff_serializer;
   localparam int unsigned N = 4;
   localparam int unsigned S = 16;

   typedef struct {
      logic [3:0] word;
      logic [3:0] sel;
      bit         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   coeff_serializer_if #(.N(N), .S(S)) bus ();

   coeff_serializer #(.N(N), .S(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t q[$];
   bit   m_busy;
   bit   m_done;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [3:0] rev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_stream(input logic [63:0] data, input logic br);
      for (int k = 0; k < int'(S); k++) begin
         exp_t e;
         logic [3:0] kk;
         kk     = 4'(k);
         e.sel  = br ? rev4(kk) : kk;
         e.word = data[e.sel*4 +: 4];
         e.last = (k == int'(S) - 1);
         q.push_back(e);
      end
   endtask

   // Check current outputs against the model, advance the model with the
   // inputs present for the coming edge, then step past that edge.
   task automatic cycle();
      bit   hs;
      exp_t e;
      hs = 1'b0;
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_busy));
      chk("done", 64'(bus.done), 64'(m_done));
      if (m_busy) begin
         if (q.size() == 0) begin
            chk("scoreboard_empty", 64'(q.size()), 64'd1);
         end else begin
            e = q[0];
            chk("out_word", 64'(bus.out_word), 64'(e.word));
            chk("sel", 64'(bus.sel), 64'(e.sel));
            if (bus.out_ready) begin
               hs = 1'b1;
               void'(q.pop_front());
            end
         end
      end
      if (rst) begin
         q.delete();
         m_busy = 1'b0;
         m_done = 1'b0;
      end else begin
         m_done = hs && e.last;
         if (m_done) m_busy = 1'b0;
         else if (!m_busy && bus.load) begin
            push_stream(bus.data_in, bus.bitrev);
            m_busy = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.load      = 1'b0;
      bus.bitrev    = 1'b0;
      bus.data_in   = '0;
      bus.out_ready = 1'b1;
      m_busy        = 1'b0;
      m_done        = 1'b0;

      @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_sel", 64'(bus.sel), 64'd0);
      chk("rst_word", 64'(bus.out_word), 64'd0);
      cycle();
      rst = 1'b0;
      cycle();

      // natural order
      bus.data_in = 64'h0123456789ABCDEF;
      bus.load    = 1'b1;
      cycle();
      bus.load = 1'b0;
      chk("nat_latency_valid", 64'(bus.out_valid), 64'd1);
      chk("nat_first_word", 64'(bus.out_word), 64'hF);
      repeat (17) cycle();
      chk("nat_end_busy", 64'(bus.busy), 64'd0);

      // bit-reversed order
      bus.bitrev = 1'b1;
      bus.load   = 1'b1;
      cycle();
      bus.load   = 1'b0;
      bus.bitrev = 1'b0;
      chk("br_sel0", 64'(bus.sel), 64'd0);
      cycle();
      chk("br_sel1", 64'(bus.sel), 64'd8);
      chk("br_word1", 64'(bus.out_word), 64'h7);
      cycle();
      chk("br_sel2", 64'(bus.sel), 64'd4);
      chk("br_word2", 64'(bus.out_word), 64'hB);
      repeat (17) cycle();

      // stall at count 5
      bus.load = 1'b1;
      cycle();
      bus.load = 1'b0;
      repeat (5) cycle();
      bus.out_ready = 1'b0;
      repeat (3) begin
         chk("stall_sel", 64'(bus.sel), 64'd5);
         chk("stall_word", 64'(bus.out_word), 64'hA);
         cycle();
      end
      bus.out_ready = 1'b1;
      cycle();
      chk("resume_sel", 64'(bus.sel), 64'd6);
      repeat (14) cycle();

      // load during stream at count 7 is ignored
      bus.data_in = 64'h0123456789ABCDEF;
      bus.load    = 1'b1;
      cycle();
      bus.load = 1'b0;
      repeat (7) cycle();
      bus.data_in = '1;
      bus.bitrev  = 1'b1;
      bus.load    = 1'b1;
      cycle();
      bus.load   = 1'b0;
      bus.bitrev = 1'b0;
      chk("ign_busy", 64'(bus.busy), 64'd1);
      chk("ign_sel", 64'(bus.sel), 64'd8);
      chk("ign_word", 64'(bus.out_word), 64'h7);
      repeat (12) cycle();

      // reset at count 9
      bus.data_in = 64'hFEDCBA9876543210;
      bus.load    = 1'b1;
      cycle();
      bus.load = 1'b0;
      repeat (9) cycle();
      rst      = 1'b1;
      bus.load = 1'b1;
      cycle();
      rst      = 1'b0;
      bus.load = 1'b0;
      chk("abort_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_sel", 64'(bus.sel), 64'd0);
      chk("abort_word", 64'(bus.out_word), 64'd0);
      cycle();
      bus.data_in = 64'h0F1E2D3C4B5A6978;
      bus.load    = 1'b1;
      cycle();
      bus.load = 1'b0;
      chk("restart_sel", 64'(bus.sel), 64'd0);
      chk("restart_word", 64'(bus.out_word), 64'h8);
      repeat (17) cycle();

      // load held high, inputs churning every cycle
      bus.load = 1'b1;
      repeat (3 * (S + 1) + 2) begin
         bus.data_in = {$urandom, $urandom};
         bus.bitrev  = 1'($urandom_range(0, 1));
         cycle();
      end
      bus.load = 1'b0;

      // random backpressure
      bus.data_in = {$urandom, $urandom};
      bus.bitrev  = 1'b1;
      bus.load    = 1'b1;
      cycle();
      bus.load = 1'b0;
      repeat (60) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      bus.out_ready = 1'b1;
      repeat (20) cycle();
      chk("final_queue_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
